// File: rtl/p21_pkg.sv
// Shared definitions for the p21 raster path: tile command encodings,
// default coordinate widths and the scan sequencer state enum.
package p21_pkg;

    localparam int unsigned P21_XW = 10;
    localparam int unsigned P21_YW = 10;

    // 2-bit command word understood by p21_tile
    localparam logic [1:0] P21_CMD_NOP     = 2'd0;
    localparam logic [1:0] P21_CMD_RESTART = 2'd1;
    localparam logic [1:0] P21_CMD_STEPY   = 2'd2;
    localparam logic [1:0] P21_CMD_STEPX   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTART = 2'd1,
        SCAN    = 2'd2
    } scan_state_e;

endpackage

// File: rtl/p21_raster_scan_if.sv
// Pixel stream from the raster sequencer toward the framebuffer writer:
// one coverage bit plus coordinates per beat, valid/ready handshake.
interface p21_raster_scan_if
    import p21_pkg::*;
#(
    parameter int unsigned XW = P21_XW,
    parameter int unsigned YW = P21_YW
);

    logic          pixel_valid;
    logic          pixel_ready;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          pixel_on;

    modport master (
        output pixel_valid,
        output pixel_x,
        output pixel_y,
        output pixel_on,
        input  pixel_ready
    );

    modport slave (
        input  pixel_valid,
        input  pixel_x,
        input  pixel_y,
        input  pixel_on,
        output pixel_ready
    );

endinterface

// File: rtl/p21_pixel_reg.sv
// Single-entry valid/ready output register. A capture may coincide with the
// consumer taking the current entry, in which case the new entry replaces it
// without a bubble.
module p21_pixel_reg #(
    parameter int unsigned DW = 21
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          capture,
    input  logic [DW-1:0] din,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] dout
);

    // Occupancy: capture wins over a plain handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
        end else if (capture) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/p21_raster_scan.sv
// Raster sequencer ahead of p21_tile: restarts the tile, walks a programmable
// window with stepx/stepy and streams one coverage bit per pixel.
// Optional P21_SCAN_STATS_EN adds the hit_count port and covered-pixel counter.
module p21_raster_scan
    import p21_pkg::*;
#(
    parameter int unsigned XW = P21_XW,
    parameter int unsigned YW = P21_YW
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [XW-1:0]        width_m1,
    input  logic [YW-1:0]        height_m1,
    output logic [1:0]           command,
    input  logic                 inside_triangle,
    p21_raster_scan_if.master    pix,
    output logic                 busy,
    output logic                 frame_done
`ifdef P21_SCAN_STATS_EN
    ,
    output logic [XW+YW-1:0]     hit_count
`endif
);

    localparam int unsigned DW = XW + YW + 1;

    scan_state_e   state_q, state_d;
    logic [XW-1:0] x_q, x_d, w_q, w_d;
    logic [YW-1:0] y_q, y_d, h_q, h_d;
    logic          advance;
    logic          accept_start;
    logic          done_d;
    logic [DW-1:0] pix_data;

    // Next-state, counter updates and the tile command for this cycle
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        w_d          = w_q;
        h_d          = h_q;
        command      = P21_CMD_NOP;
        advance      = 1'b0;
        accept_start = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    w_d          = width_m1;
                    h_d          = height_m1;
                    x_d          = '0;
                    y_d          = '0;
                    state_d      = RESTART;
                end
            end
            RESTART: begin
                command = P21_CMD_RESTART;
                state_d = SCAN;
            end
            SCAN: begin
                advance = !pix.pixel_valid || pix.pixel_ready;
                if (advance) begin
                    if (x_q != w_q) begin
                        command = P21_CMD_STEPX;
                        x_d     = x_q + XW'(1);
                    end else if (y_q != h_q) begin
                        command = P21_CMD_STEPY;
                        x_d     = '0;
                        y_d     = y_q + YW'(1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            busy       <= (state_d != IDLE);
            frame_done <= done_d;
        end
    end

    // The pixel register only captures on advance, so RESTART never
    // overwrites a pixel still pending from the previous frame.
    p21_pixel_reg #(
        .DW (DW)
    ) u_pixel_reg (
        .clock   (clock),
        .reset_n (reset_n),
        .capture (advance),
        .din     ({x_q, y_q, inside_triangle}),
        .ready   (pix.pixel_ready),
        .valid   (pix.pixel_valid),
        .dout    (pix_data)
    );

    assign {pix.pixel_x, pix.pixel_y, pix.pixel_on} = pix_data;

`ifdef P21_SCAN_STATS_EN
    localparam int unsigned HW = XW + YW;

    // Covered-pixel counter; holds after the frame until the next start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count <= '0;
        end else if (accept_start) begin
            hit_count <= '0;
        end else if (advance && inside_triangle) begin
            hit_count <= hit_count + HW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_p21_raster_scan.sv
// Directed bench for p21_raster_scan with a behavioural tile model that
// indexes a coverage pattern by its position in the walk.
module tb_p21_raster_scan;
    import p21_pkg::*;

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 10;
    localparam int unsigned DW = XW + YW + 1;

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic [XW-1:0] width_m1  = '0;
    logic [YW-1:0] height_m1 = '0;
    logic [1:0]    command;
    logic          inside_triangle;
    logic          busy;
    logic          frame_done;
`ifdef P21_SCAN_STATS_EN
    logic [XW+YW-1:0] hit_count;
`endif

    int checks = 0;
    int passed = 0;

    p21_raster_scan_if #(.XW(XW), .YW(YW)) pix ();

    p21_raster_scan #(.XW(XW), .YW(YW)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .width_m1        (width_m1),
        .height_m1       (height_m1),
        .command         (command),
        .inside_triangle (inside_triangle),
        .pix             (pix),
        .busy            (busy),
        .frame_done      (frame_done)
`ifdef P21_SCAN_STATS_EN
        ,
        .hit_count       (hit_count)
`endif
    );

    always #5 clock = ~clock;

    // Tile model: restart rewinds to pixel 0, every step moves to the next pixel
    logic [15:0] pattern  = '0;
    int unsigned tile_idx = 0;
    always @(posedge clock) begin
        case (command)
            P21_CMD_RESTART: tile_idx <= 0;
            P21_CMD_STEPX, P21_CMD_STEPY: tile_idx <= tile_idx + 1;
            default: ;
        endcase
    end
    assign inside_triangle = pattern[tile_idx[3:0]];

    // Consumer-side monitor
    logic [DW-1:0] got_q[$];
    int            done_cnt = 0;
    always @(posedge clock) begin
        if (pix.pixel_valid && pix.pixel_ready)
            got_q.push_back({pix.pixel_x, pix.pixel_y, pix.pixel_on});
        if (frame_done) done_cnt++;
    end

    // 2x2 window, coverage pattern 1,0,0,1
    logic [DW-1:0] exp_2x2 [4] = '{{10'd0, 10'd0, 1'b1}, {10'd1, 10'd0, 1'b0},
                                   {10'd0, 10'd1, 1'b0}, {10'd1, 10'd1, 1'b1}};
    logic [1:0]    exp_cmd [6] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd0, 2'd0};
    // 3x1 window, coverage pattern 1,0,1
    logic [DW-1:0] exp_3x1 [3] = '{{10'd0, 10'd0, 1'b1}, {10'd1, 10'd0, 1'b0},
                                   {10'd2, 10'd0, 1'b1}};

    // Called at a falling edge; returns at the falling edge inside cycle 1
    task automatic start_frame(input logic [XW-1:0] w, input logic [YW-1:0] h);
        got_q.delete();
        done_cnt  = 0;
        width_m1  = w;
        height_m1 = h;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && done_cnt == 0; i++) @(negedge clock);
        checks++;
        if (done_cnt != 1) $display("FAIL %s_done_count: got %0d want 1", name, done_cnt);
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (command !== 2'd0) $display("FAIL reset_command: got %0d want 0", command); else passed++;
        checks++; if (pix.pixel_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", pix.pixel_valid); else passed++;
        checks++; if ({pix.pixel_x, pix.pixel_y, pix.pixel_on} !== '0)
            $display("FAIL reset_pixel: got %h want 0", {pix.pixel_x, pix.pixel_y, pix.pixel_on}); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else passed++;
`ifdef P21_SCAN_STATS_EN
        checks++; if (hit_count !== '0) $display("FAIL reset_hit_count: got %0d want 0", hit_count); else passed++;
`endif
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_frame_2x2();
        pattern = 16'b1001;
        pix.pixel_ready = 1'b1;
        start_frame(10'd1, 10'd1);
        for (int k = 1; k <= 6; k++) begin
            #1;
            checks++; if (command !== exp_cmd[k-1])
                $display("FAIL f2x2_command_c%0d: got %0d want %0d", k, command, exp_cmd[k-1]); else passed++;
            checks++; if (busy !== (k <= 5))
                $display("FAIL f2x2_busy_c%0d: got %b want %b", k, busy, (k <= 5)); else passed++;
            checks++; if (frame_done !== (k == 6))
                $display("FAIL f2x2_frame_done_c%0d: got %b want %b", k, frame_done, (k == 6)); else passed++;
            checks++; if (pix.pixel_valid !== (k >= 3))
                $display("FAIL f2x2_valid_c%0d: got %b want %b", k, pix.pixel_valid, (k >= 3)); else passed++;
            if (k >= 3) begin
                checks++; if ({pix.pixel_x, pix.pixel_y, pix.pixel_on} !== exp_2x2[k-3])
                    $display("FAIL f2x2_pixel_c%0d: got %h want %h", k,
                             {pix.pixel_x, pix.pixel_y, pix.pixel_on}, exp_2x2[k-3]); else passed++;
            end
            @(negedge clock);
        end
        checks++; if (pix.pixel_valid !== 1'b0) $display("FAIL f2x2_valid_after: got %b want 0", pix.pixel_valid); else passed++;
        checks++; if (got_q.size() != 4) $display("FAIL f2x2_count: got %0d want 4", got_q.size()); else passed++;
    endtask

    task automatic test_frame_1x1();
        pattern = 16'b1;
        start_frame(10'd0, 10'd0);
        #1;
        checks++; if (command !== P21_CMD_RESTART) $display("FAIL f1x1_cmd_restart: got %0d want 1", command); else passed++;
        @(negedge clock); #1;
        checks++; if (command !== P21_CMD_NOP) $display("FAIL f1x1_cmd_last: got %0d want 0", command); else passed++;
        @(negedge clock); #1;
        checks++; if (frame_done !== 1'b1) $display("FAIL f1x1_frame_done: got %b want 1", frame_done); else passed++;
        checks++; if ({pix.pixel_valid, pix.pixel_x, pix.pixel_y, pix.pixel_on} !== {1'b1, 10'd0, 10'd0, 1'b1})
            $display("FAIL f1x1_pixel: got %h want %h", {pix.pixel_valid, pix.pixel_x, pix.pixel_y, pix.pixel_on},
                     {1'b1, 10'd0, 10'd0, 1'b1}); else passed++;
        @(negedge clock);
        checks++; if (got_q.size() != 1) $display("FAIL f1x1_count: got %0d want 1", got_q.size()); else passed++;
    endtask

    task automatic test_stall();
        pattern = 16'b101;
        pix.pixel_ready = 1'b1;
        start_frame(10'd2, 10'd0);
        repeat (2) @(negedge clock);
        pix.pixel_ready = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            #1;
            checks++; if (command !== P21_CMD_NOP) $display("FAIL stall_command_c%0d: got %0d want 0", k, command); else passed++;
            checks++; if ({pix.pixel_valid, pix.pixel_x} !== {1'b1, 10'd0})
                $display("FAIL stall_hold_c%0d: got valid=%b x=%0d want valid=1 x=0", k, pix.pixel_valid, pix.pixel_x); else passed++;
            @(negedge clock);
        end
        pix.pixel_ready = 1'b1;
        wait_done("stall");
        @(negedge clock);
        checks++; if (got_q.size() != 3) $display("FAIL stall_count: got %0d want 3", got_q.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (i >= got_q.size() || got_q[i] !== exp_3x1[i])
                $display("FAIL stall_pixel_%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_3x1[i]); else passed++;
        end
    endtask

    task automatic test_start_ignored();
        pattern = 16'b1001;
        start_frame(10'd1, 10'd1);
        repeat (2) @(negedge clock);
        start     = 1'b1;
        width_m1  = 10'd5;
        height_m1 = 10'd5;
        @(negedge clock);
        start = 1'b0;
        wait_done("ign");
        repeat (4) @(negedge clock);
        checks++; if (done_cnt != 1) $display("FAIL ign_extra_frame: got %0d want 1", done_cnt); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL ign_busy: got %b want 0", busy); else passed++;
        checks++; if (got_q.size() != 4) $display("FAIL ign_count: got %0d want 4", got_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (i >= got_q.size() || got_q[i] !== exp_2x2[i])
                $display("FAIL ign_pixel_%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_2x2[i]); else passed++;
        end
    endtask

    task automatic test_reset_mid_frame();
        pattern = 16'b1001;
        start_frame(10'd3, 10'd3);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if ({pix.pixel_valid, busy, command} !== 4'b0)
            $display("FAIL midrst_outputs: got valid=%b busy=%b cmd=%0d want all 0", pix.pixel_valid, busy, command); else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        start_frame(10'd1, 10'd1);
        #1;
        checks++; if (command !== P21_CMD_RESTART) $display("FAIL midrst_restart: got %0d want 1", command); else passed++;
        wait_done("midrst");
        @(negedge clock);
        checks++; if (got_q.size() != 4) $display("FAIL midrst_count: got %0d want 4", got_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (i >= got_q.size() || got_q[i] !== exp_2x2[i])
                $display("FAIL midrst_pixel_%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_2x2[i]); else passed++;
        end
    endtask

`ifdef P21_SCAN_STATS_EN
    task automatic test_stats();
        pattern = 16'b1001;
        start_frame(10'd1, 10'd1);
        wait_done("stats");
        checks++; if (hit_count !== 20'd2) $display("FAIL stats_hits: got %0d want 2", hit_count); else passed++;
        start_frame(10'd1, 10'd1);
        checks++; if (hit_count !== 20'd0) $display("FAIL stats_clear: got %0d want 0", hit_count); else passed++;
        wait_done("stats2");
        @(negedge clock);
    endtask
`endif

    initial begin
        pix.pixel_ready = 1'b1;
        test_reset();
        test_frame_2x2();
        test_frame_1x1();
        test_stall();
        test_start_ignored();
        test_reset_mid_frame();
`ifdef P21_SCAN_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule
